// File: rtl/clk_mode_ctrl.sv
// Mode sequencer for the clock's 4-digit BCD editor: RUN -> time-set -> alarm-set.
// Optional edit-idle abort is built only when MODE_TIMEOUT_EN is defined.
module clk_mode_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned TO_W        = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_m_state,
  input  logic        key_m_flag,
  input  logic        key_act,
  input  logic        ed_vld,
  input  logic [15:0] ed_data,
  input  logic [15:0] time_cur,
  input  logic [15:0] alarm_cur,
  output logic        ed_load,
  output logic        ed_en,
  output logic [15:0] ed_data_in,
  output logic        time_wr,
  output logic        alarm_wr,
  output logic [15:0] wdata,
  output logic [1:0]  mode
);

  // One-hot encoding: every Moore output is an OR of state flops, so no decode glitches.
  localparam int B_RUN  = 0;
  localparam int B_LD_T = 1;
  localparam int B_ED_T = 2;
  localparam int B_WR_T = 3;
  localparam int B_LD_A = 4;
  localparam int B_ED_A = 5;
  localparam int B_WR_A = 6;

  typedef enum logic [6:0] {
    S_RUN  = 7'b000_0001,
    S_LD_T = 7'b000_0010,
    S_ED_T = 7'b000_0100,
    S_WR_T = 7'b000_1000,
    S_LD_A = 7'b001_0000,
    S_ED_A = 7'b010_0000,
    S_WR_A = 7'b100_0000
  } state_t;

  state_t state;
  state_t state_nxt;

  logic mode_press;
  logic in_edit;
  logic timeout;

  assign mode_press = key_m_flag & ~key_m_state;
  assign in_edit    = state[B_ED_T] | state[B_ED_A];

`ifdef MODE_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;

  // Held at zero outside edit so every entry starts fresh; saturates at TO_LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (!in_edit || key_act) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LAST) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // A key press on the would-be last cycle restarts the window instead of aborting.
  assign timeout = in_edit & ~key_act & (to_cnt == TO_LAST);
`else
  logic [TO_W:0] unused_to;
  assign unused_to = {key_act, TO_W'(TIMEOUT_CYC)};
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // In edit states a confirm always wins over mode press, which wins over timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (mode_press) state_nxt = S_LD_T;
      end
      S_LD_T: state_nxt = S_ED_T;
      S_ED_T: begin
        if (ed_vld)          state_nxt = S_WR_T;
        else if (mode_press) state_nxt = S_LD_A;
        else if (timeout)    state_nxt = S_RUN;
      end
      S_WR_T: state_nxt = S_RUN;
      S_LD_A: state_nxt = S_ED_A;
      S_ED_A: begin
        if (ed_vld)          state_nxt = S_WR_A;
        else if (mode_press) state_nxt = S_RUN;
        else if (timeout)    state_nxt = S_RUN;
      end
      S_WR_A: state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata <= 16'h0;
    end else if (in_edit && ed_vld) begin
      wdata <= ed_data;
    end
  end

  assign ed_load  = state[B_LD_T] | state[B_LD_A];
  assign ed_en    = state[B_ED_T] | state[B_ED_A];
  assign time_wr  = state[B_WR_T];
  assign alarm_wr = state[B_WR_A];
  assign mode     = {state[B_LD_A] | state[B_ED_A], state[B_LD_T] | state[B_ED_T]};

  always_comb begin
    ed_data_in = 16'h0;
    if (state[B_LD_T])      ed_data_in = time_cur;
    else if (state[B_LD_A]) ed_data_in = alarm_cur;
  end

endmodule

// File: tb/tb_clk_mode_ctrl.sv
// Bench for clk_mode_ctrl: target/step model checked every cycle, write queue, directed vectors.
// Timeout vectors run only when MODE_TIMEOUT_EN is defined.
module tb_clk_mode_ctrl;

  localparam int TO_CYC = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_m_state = 1'b1;
  logic        key_m_flag = 1'b0;
  logic        key_act = 1'b0;
  logic        ed_vld = 1'b0;
  logic [15:0] ed_data = 16'h0;
  logic [15:0] time_cur = 16'h0;
  logic [15:0] alarm_cur = 16'h0;
  logic        ed_load, ed_en, time_wr, alarm_wr;
  logic [15:0] ed_data_in, wdata;
  logic [1:0]  mode;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;

  clk_mode_ctrl #(.TIMEOUT_CYC(TO_CYC), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .key_m_state(key_m_state), .key_m_flag(key_m_flag),
    .key_act(key_act), .ed_vld(ed_vld), .ed_data(ed_data), .time_cur(time_cur),
    .alarm_cur(alarm_cur), .ed_load(ed_load), .ed_en(ed_en), .ed_data_in(ed_data_in),
    .time_wr(time_wr), .alarm_wr(alarm_wr), .wdata(wdata), .mode(mode)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

`ifdef MODE_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  // ---------------- model ----------------
  // m_tgt: 0 none, 1 time, 2 alarm.  m_step: 0 loading, 1 editing, 2 writing.
  int          m_tgt = 0;
  int          m_step = 0;
  int          m_idle = 0;
  logic [15:0] m_wdata = 16'h0;
  logic [17:0] exp_q[$];

  wire m_press = key_m_flag && !key_m_state;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tgt   <= 0;
      m_step  <= 0;
      m_idle  <= 0;
      m_wdata <= 16'h0;
    end else if (m_tgt == 0) begin
      if (m_press) begin
        m_tgt  <= 1;
        m_step <= 0;
      end
    end else if (m_step == 0) begin
      m_step <= 1;
      m_idle <= 0;
    end else if (m_step == 2) begin
      m_tgt <= 0;
    end else if (ed_vld) begin
      m_step  <= 2;
      m_wdata <= ed_data;
      exp_q.push_back({(m_tgt == 2), (m_tgt == 1), ed_data});
    end else if (m_press) begin
      if (m_tgt == 1) begin
        m_tgt  <= 2;
        m_step <= 0;
      end else begin
        m_tgt <= 0;
      end
    end else if (key_act && TO_ON) begin
      m_idle <= 0;
    end else begin
      m_idle <= m_idle + 1;
      if (TO_ON && (m_idle + 1 >= TO_CYC)) m_tgt <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic        e_load;
    logic [17:0] e;
    e_load = (m_tgt != 0) && (m_step == 0);
    check("m_ed_load", 32'(ed_load), 32'(e_load));
    check("m_ed_en", 32'(ed_en), 32'((m_tgt != 0) && (m_step == 1)));
    check("m_time_wr", 32'(time_wr), 32'((m_tgt == 1) && (m_step == 2)));
    check("m_alarm_wr", 32'(alarm_wr), 32'((m_tgt == 2) && (m_step == 2)));
    check("m_mode", 32'(mode), ((m_tgt != 0) && (m_step != 2)) ? 32'(m_tgt) : 32'd0);
    check("m_ed_data_in", 32'(ed_data_in),
          e_load ? 32'((m_tgt == 1) ? time_cur : alarm_cur) : 32'd0);
    check("m_wdata", 32'(wdata), 32'(m_wdata));
    if (time_wr || alarm_wr) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'({alarm_wr, time_wr, wdata}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_txn", 32'({alarm_wr, time_wr, wdata}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    key_m_flag  = 1'b1;
    key_m_state = 1'b0;
    cycle();
    key_m_flag  = 1'b0;
    key_m_state = 1'b1;
  endtask

  logic [15:0] tv [3] = '{16'h1234, 16'h2359, 16'h0000};
  logic [15:0] ev [3] = '{16'h0959, 16'h1200, 16'h2359};

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    int wr0;
    #1 rst_n = 1'b0;
    cycle();
    cycle();
    check("rst_ed_load", 32'(ed_load), 0);
    check("rst_ed_en", 32'(ed_en), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_wr", 32'({time_wr, alarm_wr}), 0);
    rst_n = 1'b1;
    cycle();
    // Mode press ignored-inputs check: confirm strobe in RUN does nothing.
    ed_vld = 1'b1;
    ed_data = 16'h5555;
    cycle();
    ed_vld = 1'b0;
    check("run_ignore_vld", 32'({time_wr, alarm_wr, mode}), 0);

    for (int i = 0; i < 3; i++) begin
      time_cur = tv[i];
      press();
      check("ts_load", 32'(ed_load), 1);
      check("ts_load_data", 32'(ed_data_in), 32'(tv[i]));
      check("ts_load_mode", 32'(mode), 1);
      cycle();
      check("ts_en", 32'(ed_en), 1);
      check("ts_en_data", 32'(ed_data_in), 0);
      ed_data = ev[i];
      ed_vld  = 1'b1;
      cycle();
      ed_vld = 1'b0;
      check("ts_wr", 32'({alarm_wr, time_wr}), 32'b01);
      check("ts_wdata", 32'(wdata), 32'(ev[i]));
      check("ts_wr_mode", 32'(mode), 0);
      cycle();
      check("ts_after", 32'({time_wr, mode}), 0);
      check("ts_hold", 32'(wdata), 32'(ev[i]));
    end

    alarm_cur = 16'h0700;
    time_cur  = 16'h1111;
    press();
    cycle();
    press();
    check("as_load", 32'(ed_load), 1);
    check("as_load_data", 32'(ed_data_in), 32'h0700);
    check("as_mode", 32'(mode), 2);
    cycle();
    check("as_en", 32'(ed_en), 1);
    ed_data = 16'h0730;
    ed_vld  = 1'b1;
    cycle();
    ed_vld = 1'b0;
    check("as_wr", 32'({alarm_wr, time_wr}), 32'b10);
    check("as_wdata", 32'(wdata), 32'h0730);
    cycle();

    wr0 = n_wr;
    press();
    cycle();
    press();
    cycle();
    press();
    check("ab_mode", 32'({mode, ed_en, ed_load}), 0);
    cycle();
    check("ab_no_write", 32'(n_wr - wr0), 0);

    press();
    cycle();
    ed_data = 16'h0101;
    ed_vld  = 1'b1;
    key_m_flag = 1'b1;
    key_m_state = 1'b0;
    cycle();
    ed_vld = 1'b0;
    key_m_flag = 1'b0;
    key_m_state = 1'b1;
    check("col_wr", 32'({alarm_wr, time_wr}), 32'b01);
    check("col_wdata", 32'(wdata), 32'h0101);
    cycle();
    check("col_run", 32'({ed_load, mode}), 0);

`ifdef MODE_TIMEOUT_EN
    press();
    cycle();
    n = 0;
    while (ed_en && n < 60) begin
      n++;
      cycle();
    end
    check("to_cycles", 32'(n), 20);
    check("to_mode", 32'({mode, time_wr}), 0);

    press();
    cycle();
    repeat (14) cycle();
    key_act = 1'b1;
    cycle();
    key_act = 1'b0;
    n = 0;
    while (ed_en && n < 60) begin
      n++;
      cycle();
    end
    check("to_restart", 32'(n), 20);
    check("to_restart_mode", 32'(mode), 0);
`else
    press();
    cycle();
    key_act = 1'b1;
    cycle();
    key_act = 1'b0;
    repeat (60) cycle();
    check("no_to_en", 32'(ed_en), 1);
    press();
    cycle();
    press();
    check("no_to_exit", 32'(mode), 0);
`endif

    press();
    cycle();
    press();
    cycle();
    check("rm_in_eda", 32'({ed_en, mode}), 32'b110);
    rst_n = 1'b0;
    #1;
    check("rm_async", 32'({ed_load, ed_en, time_wr, alarm_wr, mode}), 0);
    check("rm_wdata", 32'(wdata), 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("rm_run", 32'({ed_load, ed_en, mode}), 0);
    cycle();
    check("q_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
